icache_line_ram: RTL and testbench

//  Parametrised instruction-cache store: DATA array plus per-line valid bits and a line-fill sequencer.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_data_ram.sv | 45 ++++
 rtl/icache_line_ram.sv | 181 ++++++++++++++++++
 tb/tb_icache_line_ram.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : icache_pkg                                                 |
// | Description : Shared definitions for the instruction-cache line store:   |
// |               the sequencer state encoding and the default geometry      |
// |               (8-bit entries, 16-byte lines, 32 lines).                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package icache_pkg;

    localparam int ICACHE_DATA_W = 8;
    localparam int ICACHE_OFFS_W = 4;
    localparam int ICACHE_LINE_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/icache_data_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_data_ram                                            |
// | Description : Single-port DEPTH x DATA_W data array clocked on the       |
// |               falling edge. A write cycle does not update the read       |
// |               register; reads are registered (one-edge latency).         |
// | Ports       : clk      - clock (falling edge active)                     |
// |               we_i     - write enable                                    |
// |               addr_i   - entry address                                   |
// |               wdata_i  - write data                                      |
// |               rdata_o  - registered read data                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int DATA_W = ICACHE_DATA_W,
    parameter int ADDR_W = ICACHE_LINE_W + ICACHE_OFFS_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are intentionally not reset; the valid bits in the parent
    // guarantee no stale entry is ever returned.
    always_ff @(negedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/icache_line_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_line_ram                                            |
// | Description : Instruction-cache store: data array, per-line valid bits   |
// |               and a miss-driven whole-line fill sequencer. Sits between  |
// |               the fetch stage (fetch port) and the bus arbiter (fill     |
// |               port). All state changes on the falling clock edge.        |
// | Ports       : clk, reset (async, active high), flush                     |
// |               fetch_req/fetch_addr/fetch_ready  - fetch request          |
// |               fetch_valid/fetch_data            - fetch response         |
// |               fill_req/fill_addr/fill_ack/fill_data - line fill beats    |
// |               busy                              - sequencer not idle     |
// |               hit_count/miss_count              - lookup statistics      |
// | Options     : ICACHE_STATS_EN - adds STAT_W and the saturating           |
// |               hit_count/miss_count ports.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module icache_line_ram
    import icache_pkg::*;
#(
    parameter int DATA_W = ICACHE_DATA_W,
    parameter int OFFS_W = ICACHE_OFFS_W,
    parameter int LINE_W = ICACHE_LINE_W
`ifdef ICACHE_STATS_EN
   ,parameter int STAT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     fetch_req,
    input  logic [LINE_W+OFFS_W-1:0] fetch_addr,
    output logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_data,
    output logic                     fill_req,
    output logic [LINE_W+OFFS_W-1:0] fill_addr,
    input  logic                     fill_ack,
    input  logic [DATA_W-1:0]        fill_data,
    output logic                     busy
`ifdef ICACHE_STATS_EN
   ,output logic [STAT_W-1:0]        hit_count,
    output logic [STAT_W-1:0]        miss_count
`endif
);

    localparam int ADDR_W = LINE_W + OFFS_W;
    localparam int NLINES = 2**LINE_W;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   fill_addr_q;
    logic [NLINES-1:0]   valid_q;
    logic                fill_req_q;
    logic                fetch_valid_q;
    logic [DATA_W-1:0]   fetch_data_q;

    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic [LINE_W-1:0]   w_line;
    logic                w_hit;
    logic                w_last_beat;

    assign w_line      = addr_q[ADDR_W-1:OFFS_W];
    assign w_hit       = valid_q[w_line];
    assign w_last_beat = (fill_addr_q[OFFS_W-1:0] == {OFFS_W{1'b1}});

    // The single RAM port is shared: fill writes take it, otherwise it reads
    // the latched fetch address (the LOOKUP read feeds the RESP cycle).
    assign w_ram_we   = (state_q == FILL) && fill_ack && !flush;
    assign w_ram_addr = w_ram_we ? fill_addr_q : addr_q;

    icache_data_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .addr_i  (w_ram_addr),
        .wdata_i (fill_data),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            fill_addr_q   <= '0;
            valid_q       <= '0;
            fill_req_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            fetch_valid_q <= 1'b0;
            if (flush) begin
                // Flush wins over everything: drop any pending fetch or fill.
                valid_q    <= '0;
                fill_req_q <= 1'b0;
                state_q    <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fetch_req) begin
                            addr_q  <= fetch_addr;
                            state_q <= LOOKUP;
                        end
                    end
                    LOOKUP: begin
                        if (w_hit) begin
                            state_q <= RESP;
                        end else begin
                            fill_addr_q <= {w_line, {OFFS_W{1'b0}}};
                            fill_req_q  <= 1'b1;
                            state_q     <= FILL;
                        end
                    end
                    FILL: begin
                        if (fill_ack) begin
                            if (w_last_beat) begin
                                // Line complete; the re-lookup is a guaranteed hit.
                                valid_q[w_line] <= 1'b1;
                                fill_req_q      <= 1'b0;
                                state_q         <= LOOKUP;
                            end else begin
                                fill_addr_q <= fill_addr_q + 1'b1;
                            end
                        end
                    end
                    RESP: begin
                        fetch_valid_q <= 1'b1;
                        fetch_data_q  <= w_ram_rdata;
                        state_q       <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fetch_ready = (state_q == IDLE) && !flush;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fill_req    = fill_req_q;
    assign fill_addr   = fill_addr_q;
    assign busy        = (state_q != IDLE);

`ifdef ICACHE_STATS_EN
    logic              stat_arm_q;
    logic [STAT_W-1:0] hit_cnt_q;
    logic [STAT_W-1:0] miss_cnt_q;

    // stat_arm_q marks the LOOKUP that directly follows an accepted request,
    // so the re-lookup after a fill is not counted a second time.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stat_arm_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            stat_arm_q <= fetch_ready && fetch_req;
            if (stat_arm_q && (state_q == LOOKUP) && !flush) begin
                if (w_hit) begin
                    if (hit_cnt_q != {STAT_W{1'b1}}) begin
                        hit_cnt_q <= hit_cnt_q + 1'b1;
                    end
                end else begin
                    if (miss_cnt_q != {STAT_W{1'b1}}) begin
                        miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_line_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_icache_line_ram                                         |
// | Description : Randomised scoreboard bench for icache_line_ram. A bus     |
// |               responder serves fills from a backing memory with random   |
// |               ack delays; a line-level valid model predicts hit/miss and |
// |               fetch data; a monitor pops expected responses.             |
// | Options     : ICACHE_STATS_EN - also checks hit_count/miss_count.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_icache_line_ram;

    localparam int DATA_W = 8;
    localparam int OFFS_W = 4;
    localparam int LINE_W = 5;
    localparam int ADDR_W = 9;
    localparam int NLINES = 32;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_ack = 1'b0;
    logic [DATA_W-1:0] fill_data = '0;
    logic              busy;
`ifdef ICACHE_STATS_EN
    localparam int STAT_W = 16;
    logic [STAT_W-1:0] hit_count;
    logic [STAT_W-1:0] miss_count;
    int                exp_hits   = 0;
    int                exp_misses = 0;
`endif

    always #5 clk = ~clk;

    icache_line_ram #(
        .DATA_W (DATA_W),
        .OFFS_W (OFFS_W),
        .LINE_W (LINE_W)
`ifdef ICACHE_STATS_EN
       ,.STAT_W (STAT_W)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fill_req    (fill_req),
        .fill_addr   (fill_addr),
        .fill_ack    (fill_ack),
        .fill_data   (fill_data),
        .busy        (busy)
`ifdef ICACHE_STATS_EN
       ,.hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    // ---------------- reference state ----------------
    logic [DATA_W-1:0] backing [DEPTH];
    bit                line_valid [NLINES];
    logic [DATA_W-1:0] exp_q [$];
    logic [ADDR_W-1:0] beat_q [$];
    int                resp_cnt    = 0;
    longint            last_valid_t = 0;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NLINES; i++) line_valid[i] = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        if (fetch_valid === 1'b1) begin
            resp_cnt++;
            last_valid_t = $time;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_fetch_valid: got data %0h expected no response (t=%0t)",
                         fetch_data, $time);
            end else begin
                check("fetch_data", 32'(fetch_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- fill bus responder ----------------
    int                wait_cnt  = 0;
    logic              prev_req  = 1'b0;
    logic              prev_ack  = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(posedge clk) begin
        if (fill_req === 1'b1 && prev_req && !prev_ack)
            check("fill_addr_stable", 32'(fill_addr), 32'(prev_addr));
        if (fill_req === 1'b1) begin
            if (wait_cnt == 0) begin
                fill_ack  = 1'b1;
                fill_data = backing[fill_addr];
                beat_q.push_back(fill_addr);
                wait_cnt  = int'($urandom_range(0, 3));
            end else begin
                fill_ack  = 1'b0;
                fill_data = 8'($urandom);
                wait_cnt--;
            end
        end else begin
            // Stray acks while no fill is requested must be ignored.
            fill_ack  = ($urandom_range(0, 3) == 0);
            fill_data = 8'($urandom);
        end
        prev_req  = fill_req;
        prev_ack  = fill_ack;
        prev_addr = fill_addr;
    end

    // ---------------- one complete fetch ----------------
    task automatic do_fetch(input logic [ADDR_W-1:0] a);
        int              guard;
        int              base;
        int              r0;
        int              n;
        int              mism;
        longint          t0;
        bit              hit;
        logic [LINE_W-1:0] ln;
        ln = a[ADDR_W-1:OFFS_W];
        tick();
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            tick();
            guard++;
        end
        hit  = line_valid[ln];
        base = beat_q.size();
        r0   = resp_cnt;
        exp_q.push_back(backing[a]);
        fetch_req  = 1'b1;
        fetch_addr = a;
        t0 = $time;
        tick();
        fetch_req  = 1'b0;
        fetch_addr = 9'($urandom);
        guard = 0;
        while (resp_cnt == r0 && guard < 300) begin
            tick();
            guard++;
        end
        if (resp_cnt == r0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: got no fetch_valid expected response for addr %0h", a);
            exp_q.delete();
            return;
        end
        if (hit)
            check("hit_latency", 32'((last_valid_t + 1 - t0) / 10), 32'd3);
        n = beat_q.size() - base;
        check("fill_beats", 32'(n), hit ? 32'd0 : 32'd16);
        if (!hit && n == 16) begin
            mism = 0;
            for (int i = 0; i < 16; i++)
                if (beat_q[base + i] !== {ln, 4'(i)}) mism++;
            check("fill_addr_seq", 32'(mism), 32'd0);
        end
        line_valid[ln] = 1'b1;
`ifdef ICACHE_STATS_EN
        if (hit) begin
            if (exp_hits < (1 << STAT_W) - 1) exp_hits++;
        end else begin
            if (exp_misses < (1 << STAT_W) - 1) exp_misses++;
        end
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        int base;
        int r0;
        logic [2:0] rl;

        reset      = 1'b1;
        flush      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        for (int i = 0; i < DEPTH; i++) backing[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) backing[i] = 8'(i);
        clear_model();

        repeat (3) tick();
        check("rst_fill_req",    32'(fill_req),    32'd0);
        check("rst_fill_addr",   32'(fill_addr),   32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_data",  32'(fetch_data),  32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        reset = 1'b0;
        tick();
        check("rst_fetch_ready", 32'(fetch_ready), 32'd1);

        // Cold miss on line 0, then hits within the same line.
        do_fetch(9'h000);
        do_fetch(9'h005);
        for (int i = 0; i < 4; i++) do_fetch(9'($urandom_range(0, 15)));
`ifdef ICACHE_STATS_EN
        check("stats_hits_5",   32'(hit_count),  32'd5);
        check("stats_misses_1", 32'(miss_count), 32'd1);
`endif

        // Flush in the middle of filling line 3.
        tick();
        base = beat_q.size();
        r0   = resp_cnt;
        fetch_req  = 1'b1;
        fetch_addr = 9'h030;
        tick();
        fetch_req  = 1'b0;
        guard = 0;
        while ((beat_q.size() - base) < 7 && guard < 300) begin
            tick();
            guard++;
        end
        check("flush_fill_progress", 32'(beat_q.size() - base >= 7), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fill_req", 32'(fill_req), 32'd0);
        check("flush_busy",     32'(busy),     32'd0);
        repeat (10) tick();
        check("flush_no_resp", 32'(resp_cnt - r0), 32'd0);
        clear_model();
`ifdef ICACHE_STATS_EN
        exp_misses++;
`endif
        do_fetch(9'h030);

        // flush and fetch_req together while idle: request must be refused.
        do_fetch(9'h00A);
        tick();
        flush      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 9'h00A;
        #1;
        check("flush_req_ready", 32'(fetch_ready), 32'd0);
        tick();
        flush     = 1'b0;
        fetch_req = 1'b0;
        check("flush_req_no_lookup", 32'(busy), 32'd0);
        clear_model();
        do_fetch(9'h00A);

        // Random traffic over the first 8 lines.
        for (int k = 0; k < 30; k++) begin
            rl = 3'($urandom_range(0, 7));
            do_fetch({2'b00, rl, 4'($urandom)});
        end
`ifdef ICACHE_STATS_EN
        check("stats_hits",   32'(hit_count),  32'(exp_hits));
        check("stats_misses", 32'(miss_count), 32'(exp_misses));
`endif

        // Asynchronous reset in the middle of a fill.
        tick();
        base = beat_q.size();
        fetch_req  = 1'b1;
        fetch_addr = 9'h095;
        tick();
        fetch_req  = 1'b0;
        guard = 0;
        while ((beat_q.size() - base) < 3 && guard < 300) begin
            tick();
            guard++;
        end
        reset = 1'b1;
        #1;
        check("rst_mid_fill_req",  32'(fill_req), 32'd0);
        check("rst_mid_fill_busy", 32'(busy),     32'd0);
        tick();
        reset = 1'b0;
        clear_model();
`ifdef ICACHE_STATS_EN
        exp_hits   = 0;
        exp_misses = 0;
        check("rst_stats_hits",   32'(hit_count),  32'd0);
        check("rst_stats_misses", 32'(miss_count), 32'd0);
`endif
        do_fetch(9'h095);
        do_fetch(9'h09C);

        repeat (5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
